// File: rtl/i2c_regfile_if.sv
// Register-access bus between the I2C slave front end and the register file.
// The slave decodes I2C frames into address/strobe cycles; the register file answers with rdata.
interface i2c_regfile_if;
  logic       rw;
  logic [7:0] addr;
  logic       wen;
  logic [7:0] wdata;
  logic       rdata_used;
  logic [7:0] rdata;

  modport master (output rw, addr, wen, wdata, rdata_used, input rdata);
  modport slave  (input rw, addr, wen, wdata, rdata_used, output rdata);
endinterface

// File: rtl/i2c_regfile.sv
// I2C-facing register file: eight general registers, a status/ID block and a
// mailbox FIFO toward the core, with a level interrupt for pending mail or overflow.
module i2c_regfile #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_regfile_if.slave      bus,
  output logic [63:0]       regs_out,
  output logic              fifo_valid,
  output logic [7:0]        fifo_data,
  input  logic              fifo_ready,
  output logic              irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_PUSH   = 8'h09;
  localparam logic [7:0] ADDR_ID     = 8'h0A;

  logic [7:0]       regs [8];
  logic [7:0]       mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [4:0]       count;
  logic             ovf;

  logic       full;
  logic       empty;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       ovf_clear;
  logic [7:0] status;
  logic [7:0] rd_next;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == 5'd0);
  assign push_req  = bus.wen && (bus.addr == ADDR_PUSH);
  assign push      = push_req && !full;
  assign pop       = !empty && fifo_ready;
  assign ovf_clear = bus.wen && (bus.addr == ADDR_STATUS) && bus.wdata[7];
  assign status    = {ovf, empty, full, count};

  // rw and rdata_used are carried on the bus for the slave's benefit only.
  logic unused_bus;
  assign unused_bus = ^{bus.rw, bus.rdata_used};

  // General registers R0..R7.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (bus.wen && (bus.addr[7:3] == 5'd0)) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      regs[bus.addr[2:0]] <= bus.wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) regs_out[i*8 +: 8] = regs[i];
  end

  // NOTE: mailbox storage is deliberately not reset; count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Overflow is sticky; a same-cycle set beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                  ovf <= 1'b0;
    else if (push_req && full)   ovf <= 1'b1;
    else if (ovf_clear)          ovf <= 1'b0;
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_next and no latch is inferred.
    rd_next = 8'h00;
    if (bus.addr[7:3] == 5'd0) begin
      rd_next = regs[bus.addr[2:0]];
    end else begin
      case (bus.addr)
        ADDR_STATUS: rd_next = status;
        ADDR_ID:     rd_next = ID_VALUE;
        default:     rd_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus.rdata <= 8'h00;
    else        bus.rdata <= rd_next;
  end

  assign fifo_valid = !empty;
  assign fifo_data  = mem[head];
  assign irq        = fifo_valid || ovf;

endmodule

// File: doc/i2c_regfile.md
I2C_REGFILE -- requirements
Module: i2c_regfile

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning mailbox FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, meaning constant returned at address 0x0A.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 rw  input  1  transaction direction from the I2C slave; 1 = read; informational only.
REQ-006 addr  input  8  register address from the I2C slave.
REQ-007 wen  input  1  one-cycle write strobe from the I2C slave.
REQ-008 wdata  input  8  write data, valid while wen=1.
REQ-009 rdata_used  input  1  one-cycle pulse: the slave consumed rdata for addr.
REQ-010 rdata  output  8  registered read data for the current addr.
REQ-011 regs_out  output  64  flat copy of general registers R0..R7; R0 in bits 7:0.
REQ-012 fifo_valid  output  1  mailbox FIFO non-empty.
REQ-013 fifo_data  output  8  FIFO head entry; valid when fifo_valid=1.
REQ-014 fifo_ready  input  1  core pops the head when fifo_valid and fifo_ready are both 1.
REQ-015 irq  output  1  level: FIFO non-empty or overflow flag set.

Function
REQ-016 Address map SHALL be:
- 0x00-0x07: R0-R7, read/write.
- 0x08: STATUS, read; write clears flags.
- 0x09: FIFO push, write-only; reads return 0x00.
- 0x0A: ID_VALUE, read-only.
- All other addresses: read 0x00, writes ignored.
REQ-017 STATUS bits SHALL be:
- [4:0] count, the FIFO occupancy, 0..FIFO_DEPTH.
- [5] full.
- [6] empty.
- [7] ovf, a sticky overflow flag.
REQ-018 wen=1 with addr in 0x00-0x07 SHALL load wdata into that register on that clock edge.
REQ-019 wen=1 at 0x08 SHALL clear ovf if wdata[7]=1 and SHALL otherwise be ignored.
REQ-020 wen=1 at 0x09 with FIFO not full SHALL push wdata at the tail; count increments next cycle.
REQ-021 wen=1 at 0x09 with FIFO full SHALL discard wdata, leave FIFO contents unchanged, and set ovf.
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 A push and a pop in the same cycle while full SHALL discard the push, set ovf, and still pop.
REQ-024 A push and a pop in the same cycle while empty SHALL be impossible: pop requires fifo_valid.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL be a separate counter.
REQ-026 fifo_data SHALL be read combinationally from the head pointer.
REQ-027 fifo_valid SHALL be (count != 0) as a registered-state decode.
REQ-028 rdata SHALL be registered: each cycle rdata <= readmux(addr) using the register state before that edge's writes.
REQ-029 Read latency: rdata SHALL reflect a new addr one cycle after addr changes.
REQ-030 A same-cycle write SHALL be visible in rdata one further cycle later.
REQ-031 rdata_used SHALL have no side effect on any register or the FIFO; it is reserved.
REQ-032 A simultaneous ovf set (REQ-021) and clear (REQ-019) SHALL be impossible, since one wen carries one address.
REQ-033 A set SHALL win over a clear on any other same-cycle conflict.
REQ-034 irq SHALL equal fifo_valid OR ovf, driven from registered state.
REQ-035 regs_out SHALL be driven directly from the R0..R7 flops with no added latency.

Reset
REQ-036 rst_n=0 at a clock edge SHALL set:
- R0-R7 to 0x00.
- FIFO pointers and count to 0.
- ovf to 0.
- rdata to 0x00.
REQ-037 In reset, regs_out=0, fifo_valid=0 and irq=0.
REQ-038 Reset SHALL take priority over wen and fifo_ready in the same cycle.
REQ-039 FIFO storage contents SHALL need no reset.
REQ-040 Reset asserted mid-operation SHALL discard FIFO contents and ovf, returning all outputs to their REQ-036/037 values on the next edge.

Verification
REQ-041 Write test: wen at 0x03 with 0x5C, then addr=0x03 -> rdata=0x5C after 1 cycle; regs_out[31:24]=0x5C.
REQ-042 Push/pop order: push 0x11, 0x22, 0x33 -> STATUS=0x03; fifo_data=0x11; pops with fifo_ready=1 yield 0x11, 0x22, 0x33; then STATUS=0x40, irq=0.
REQ-043 Overflow: push 5 bytes with FIFO_DEPTH=4 -> STATUS=0xA4, 5th byte lost, irq=1.
REQ-044 Overflow clear: write 0x80 to 0x08 -> STATUS=0x24.
REQ-045 Full concurrency: full FIFO, push and pop in the same cycle -> count=3, ovf=1, head advances.
REQ-046 Read map: addr=0x0A -> rdata=0xA5; addr=0x09 or 0x40 -> rdata=0x00.
REQ-047 Mid-operation reset: rst_n=0 for 1 cycle with 2 entries queued and R7=0xFF -> fifo_valid=0, regs_out=0, rdata=0x00 next cycle.
